// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts one clipped rectangle command and streams one
// RGB332 byte write per covered pixel, in raster order, to the framebuffer port.
module rect_fill_engine #(
  parameter int H  = 640,
  parameter int V  = 400,
  parameter int AW = 32
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [9:0]    cmd_x,
  input  logic [9:0]    cmd_y,
  input  logic [9:0]    cmd_w,
  input  logic [9:0]    cmd_h,
  input  logic [7:0]    cmd_color,
  input  logic          wr_en,
  output logic          cpu_wr,
  output logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [10:0]   HL = 11'(H);
  localparam logic [10:0]   VL = 11'(V);
  localparam logic [AW-1:0] HA = AW'(H);

  state_t        r_state, w_state;
  logic [9:0]    r_x, r_y, r_w, r_h, r_cx, r_cy;
  logic [9:0]    w_x, w_y, w_w, w_h, w_cx, w_cy;
  logic [7:0]    r_color, w_color;
  logic [10:0]   r_x_end, r_y_end, w_x_end, w_y_end;
  logic [AW-1:0] r_row_base, w_row_base;
  logic          r_cpu_wr, w_cpu_wr;
  logic [AW-1:0] r_cpu_addr, w_cpu_addr;
  logic [7:0]    r_cpu_data, w_cpu_data;
  logic          r_cmd_ready, w_cmd_ready;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  // 11-bit clip arithmetic: 1023 + 1023 still fits, so no wrap is possible
  logic [10:0] w_x_sum, w_y_sum, w_x_clip, w_y_clip;
  logic        w_empty, w_last_col, w_last_row;

  assign w_x_sum    = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_sum    = {1'b0, r_y} + {1'b0, r_h};
  assign w_x_clip   = (w_x_sum > HL) ? HL : w_x_sum;
  assign w_y_clip   = (w_y_sum > VL) ? VL : w_y_sum;
  assign w_empty    = (r_w == 10'd0) || (r_h == 10'd0) ||
                      ({1'b0, r_x} >= HL) || ({1'b0, r_y} >= VL);
  assign w_last_col = ({1'b0, r_cx} == (r_x_end - 11'd1));
  assign w_last_row = ({1'b0, r_cy} == (r_y_end - 11'd1));

  // Next-state and next-output logic for the command FSM
  always_comb begin
    w_state     = r_state;
    w_x         = r_x;
    w_y         = r_y;
    w_w         = r_w;
    w_h         = r_h;
    w_color     = r_color;
    w_x_end     = r_x_end;
    w_y_end     = r_y_end;
    w_cx        = r_cx;
    w_cy        = r_cy;
    w_row_base  = r_row_base;
    w_cpu_wr    = 1'b0;
    w_cpu_addr  = r_cpu_addr;
    w_cpu_data  = r_cpu_data;
    w_cmd_ready = r_cmd_ready;
    w_busy      = r_busy;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_x         = cmd_x;
          w_y         = cmd_y;
          w_w         = cmd_w;
          w_h         = cmd_h;
          w_color     = cmd_color;
          w_cmd_ready = 1'b0;
          w_busy      = 1'b1;
          w_state     = S_CLIP;
        end else begin
          w_cmd_ready = 1'b1;
          w_busy      = 1'b0;
        end
      end
      S_CLIP: begin
        w_x_end = w_x_clip;
        w_y_end = w_y_clip;
        if (w_empty) begin
          w_state = S_DONE;
        end else begin
          w_cx       = r_x;
          w_cy       = r_y;
          w_row_base = AW'(r_y) * HA;
          w_state    = S_FILL;
        end
      end
      S_FILL: begin
        if (wr_en) begin
          w_cpu_wr   = 1'b1;
          w_cpu_addr = r_row_base + AW'(r_cx);
          w_cpu_data = r_color;
          if (w_last_col) begin
            w_cx       = r_x;
            w_cy       = r_cy + 10'd1;
            w_row_base = r_row_base + HA;
            if (w_last_row) begin
              w_state = S_DONE;
            end else begin
              w_state = S_FILL;
            end
          end else begin
            w_cx = r_cx + 10'd1;
          end
        end else begin
          w_cpu_wr = 1'b0;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        w_state     = S_IDLE;
      end
      default: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        w_state     = S_IDLE;
      end
    endcase
  end

  // State, captured command and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_w         <= 10'd0;
      r_h         <= 10'd0;
      r_color     <= 8'd0;
      r_x_end     <= 11'd0;
      r_y_end     <= 11'd0;
      r_cx        <= 10'd0;
      r_cy        <= 10'd0;
      r_row_base  <= '0;
      r_cpu_wr    <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_data  <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_x         <= w_x;
      r_y         <= w_y;
      r_w         <= w_w;
      r_h         <= w_h;
      r_color     <= w_color;
      r_x_end     <= w_x_end;
      r_y_end     <= w_y_end;
      r_cx        <= w_cx;
      r_cy        <= w_cy;
      r_row_base  <= w_row_base;
      r_cpu_wr    <= w_cpu_wr;
      r_cpu_addr  <= w_cpu_addr;
      r_cpu_data  <= w_cpu_data;
      r_cmd_ready <= w_cmd_ready;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cpu_wr    = r_cpu_wr;
  assign cpu_addr  = r_cpu_addr;
  assign cpu_data  = r_cpu_data;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: vector table plus scoreboard of
// expected framebuffer writes, with hand sequences for stall, back-to-back and reset.
module tb_rect_fill_engine;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = 10'd0, cmd_y = 10'd0, cmd_w = 10'd0, cmd_h = 10'd0;
  logic [7:0]  cmd_color = 8'd0;
  logic        wr_en = 1'b1;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        busy, done;

  rect_fill_engine #(.H(640), .V(400), .AW(32)) dut (
    .pclk(pclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .wr_en(wr_en), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .busy(busy), .done(done)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int x, y, w, h;
    logic [7:0] c;
    int n;
    int last;
  } vec_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  first_wr_cyc = -1;
  int  first_addr = -1;
  int  last_addr = -1;

  always @(posedge pclk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every observed write is matched against the oldest expected one
  always @(negedge pclk) begin
    if (cpu_wr === 1'b1) begin
      wr_count++;
      if (first_wr_cyc < 0) begin
        first_wr_cyc = cyc;
        first_addr   = int'(cpu_addr);
      end
      last_addr = int'(cpu_addr);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d with nothing expected", cpu_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (cpu_addr !== e.addr || cpu_data !== e.data) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %02h expected addr %0d data %02h",
                   cpu_addr, cpu_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_model(input int x, input int y, input int w, input int h,
                            input logic [7:0] c);
    int xe, ye;
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 400) ? 400 : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back('{32'(yy * 640 + xx), c});
  endtask

  task automatic clear_counts();
    wr_count     = 0;
    first_wr_cyc = -1;
    first_addr   = -1;
    last_addr    = -1;
  endtask

  // Drive one command at a negedge; returns k, the cycle count after the acceptance edge
  task automatic start_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] c, output int k);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    clear_counts();
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    push_model(x, y, w, h, c);
    @(negedge pclk);
    k = cyc;
    cmd_valid = 1'b0;
    check("accept_ready_low", cmd_ready, 0);
    check("accept_busy_high", busy, 1);
  endtask

  task automatic wait_done(input int bound, output int dc);
    int early;
    bit seen;
    early = 0;
    seen  = 1'b0;
    dc    = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge pclk);
      if (done === 1'b1) begin
        seen = 1'b1;
        dc   = cyc;
      end else if (cmd_ready === 1'b1) begin
        early++;
      end
    end
    check("done_seen", seen, 1);
    check("ready_stays_low_while_busy", early, 0);
  endtask

  vec_t vecs[9];
  int   k, dc, k2, dc2;
  logic pat[7];

  initial begin
    vecs[0] = '{10, 2, 3, 2, 8'hE0, 6, 1932};
    vecs[1] = '{638, 399, 5, 5, 8'h1C, 2, 255999};
    vecs[2] = '{5, 5, 0, 3, 8'hAA, 0, 0};
    vecs[3] = '{5, 5, 3, 0, 8'h55, 0, 0};
    vecs[4] = '{640, 0, 4, 4, 8'h11, 0, 0};
    vecs[5] = '{0, 400, 4, 4, 8'h22, 0, 0};
    vecs[6] = '{1023, 1023, 1023, 1023, 8'h33, 0, 0};
    vecs[7] = '{630, 10, 100, 1, 8'h07, 10, 7039};
    vecs[8] = '{0, 398, 1, 100, 8'h42, 2, 255360};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cpu_wr", cpu_wr, 0);
    check("rst_cpu_addr", cpu_addr, 0);
    check("rst_cpu_data", cpu_data, 0);
    rst_n = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 9; i++) begin
      start_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, k);
      wait_done(vecs[i].n + 20, dc);
      check("write_count", wr_count, vecs[i].n);
      check("queue_empty", exp_q.size(), 0);
      check("done_cycle", dc, k + 2 + vecs[i].n);
      if (vecs[i].n > 0) begin
        check("first_write_cycle", first_wr_cyc, k + 2);
        check("last_addr", last_addr, vecs[i].last);
        check("done_after_last_write", dc, first_wr_cyc + vecs[i].n);
      end else begin
        check("no_write_seen", first_wr_cyc, -1);
      end
      check("done_ready_back", cmd_ready, 1);
      check("done_busy_low", busy, 0);
      @(negedge pclk);
      check("done_one_cycle", done, 0);
    end

    // Stall pattern: only wr_en=1 cycles produce writes, addresses hold otherwise
    start_cmd(0, 0, 4, 1, 8'h5A, k);
    @(negedge pclk);
    for (int i = 0; i < 7; i++) begin
      wr_en = pat[i];
      @(negedge pclk);
      check("stall_wr", cpu_wr, pat[i]);
      if (i == 1 || i == 2) check("stall_hold_addr0", cpu_addr, 0);
      if (i == 4) check("stall_hold_addr1", cpu_addr, 1);
      if (i == 4) check("stall_hold_data", cpu_data, 8'h5A);
    end
    wr_en = 1'b1;
    wait_done(10, dc);
    check("stall_done_cycle", dc, k + 9);
    check("stall_write_count", wr_count, 4);
    check("stall_queue_empty", exp_q.size(), 0);
    @(negedge pclk);

    // Back-to-back: second command held valid while the first fills
    start_cmd(0, 380, 640, 20, 8'h03, k);
    cmd_x = 10'd0; cmd_y = 10'd300; cmd_w = 10'd320; cmd_h = 10'd100;
    cmd_color = 8'hFF;
    cmd_valid = 1'b1;
    push_model(0, 300, 320, 100, 8'hFF);
    wait_done(13000, dc);
    check("b2b_first_count", wr_count, 12800);
    check("b2b_first_last", last_addr, 255999);
    check("b2b_first_done_cycle", dc, k + 2 + 12800);
    check("b2b_ready_at_done", cmd_ready, 1);
    clear_counts();
    @(negedge pclk);
    k2 = cyc;
    cmd_valid = 1'b0;
    check("b2b_second_accepted", busy, 1);
    check("b2b_second_ready_low", cmd_ready, 0);
    wait_done(32100, dc2);
    check("b2b_second_count", wr_count, 32000);
    check("b2b_second_first", first_addr, 192000);
    check("b2b_second_last", last_addr, 255679);
    check("b2b_second_done_cycle", dc2, k2 + 2 + 32000);
    check("b2b_queue_empty", exp_q.size(), 0);
    @(negedge pclk);

    // Reset in the middle of a full-screen fill
    start_cmd(0, 0, 640, 400, 8'h03, k);
    repeat (50) @(negedge pclk);
    check("pre_reset_writing", cpu_wr, 1);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cpu_wr", cpu_wr, 0);
    check("mid_rst_cpu_addr", cpu_addr, 0);
    check("mid_rst_cpu_data", cpu_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    exp_q.delete();
    clear_counts();
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (30) @(negedge pclk);
    check("post_rst_no_writes", wr_count, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Upstream pixel-write source for the vga framebuffer write port (cpu_wr/cpu_addr/cpu_data). It accepts one rectangle-fill command at a time through a valid/ready handshake. It clips the rectangle to the visible 640x400 area, then emits one framebuffer byte write per pixel in raster order. All writes use the same RGB332 colour, and the fill can be throttled by a write-enable input. The block replaces ad-hoc per-pixel pattern generators in the top level.

Parameters:
H, 640, visible width in pixels (framebuffer stride)
V, 400, visible height in pixels
AW, 32, framebuffer address width

Ports:
pclk  in  1  pixel/system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_x  in  10  left column of rectangle
cmd_y  in  10  top row of rectangle
cmd_w  in  10  width in pixels
cmd_h  in  10  height in pixels
cmd_color  in  8  RGB332 fill value
wr_en  in  1  1 = a write may be issued this cycle; 0 = stall
cpu_wr  out  1  framebuffer write strobe, one pixel per high cycle
cpu_addr  out  AW  framebuffer byte address, y*H + x
cpu_data  out  8  pixel value
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE, cmd_ready=1, busy=0, done=0
  - cpu_wr=0, cpu_addr=0, cpu_data=0
  - Reset mid-fill aborts the command; nothing resumes after release.
- All outputs are registered.
- States: IDLE -> CLIP -> FILL -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready at edge k, capture all cmd_* fields and go to CLIP. cmd_ready and busy reflect this after edge k (cmd_ready=0, busy=1).
- CLIP (exactly 1 cycle):
  - x_end=min(x+w,H) and y_end=min(y+h,V), computed in 11-bit arithmetic so there is no overflow.
  - If w==0, h==0, x>=H or y>=V: go to DONE with no writes.
  - Otherwise: cx=x, cy=y, row_base=y*H (shift-add allowed; multiplier not required). Go to FILL.
- FILL:
  - Each cycle with wr_en=1: register cpu_wr=1, cpu_addr=row_base+cx, cpu_data=color, then advance.
  - If cx==x_end-1: cx=x, cy=cy+1, row_base+=H. Otherwise cx=cx+1.
  - The write with cx==x_end-1 and cy==y_end-1 is the last one; go to DONE.
  - Each cycle with wr_en=0: cpu_wr=0 and counters hold. cpu_addr/cpu_data hold their last values.
  - No pixel is skipped or duplicated across stalls.
  - First cpu_wr appears after edge k+2, given wr_en=1.
- DONE (1 cycle):
  - done=1, cpu_wr=0, then go to IDLE.
  - cmd_ready=1 and busy=0 after the following edge.
  - Minimum command spacing: pixels+3 cycles.
- cmd_valid while busy is ignored; the captured command cannot change mid-fill.
- Writes per command = (x_end-x)*(y_end-y), with cpu_addr always < H*V.
- cmd_color captured at acceptance is used for the whole command.

Test Plan:
1. Reset: assert rst_n=0 mid-FILL -> cpu_wr=0, cpu_addr=0, cpu_data=0, busy=0, cmd_ready=1 immediately (before next edge); no writes after release.
2. Basic fill: x=10,y=2,w=3,h=2,color=0xE0, wr_en=1 -> exactly 6 consecutive writes at addresses 1290,1291,1292,1930,1931,1932 with data 0xE0; first write after acceptance edge+2; done pulses 1 cycle after the last write.
3. Clipping: x=638,y=399,w=5,h=5,color=0x1C -> exactly 2 writes, at 255998 and 255999; no address >=256000.
4. Degenerate: w=0 (then h=0, then x=640) -> zero cpu_wr cycles; done pulses 2 cycles after acceptance; cmd_ready returns next cycle.
5. Stall: x=0,y=0,w=4,h=1, wr_en pattern 1,0,0,1,0,1,1 -> writes at addresses 0,1,2,3 only on wr_en=1 cycles, in order, no duplicates.
6. Full screen then back-to-back: command (0,0,640,400,0x03) held valid with a second command (0,300,320,100,0xFF) -> 256000 writes ending at address 255999; second command accepted only after done; 32000 writes spanning 192000..255679.
